// File: rtl/usb_txn_pkg.sv
// usb_txn_pkg: shared types for the USB host transaction sequencer.
// Holds the packet identifiers, the sequencer state encoding and a
// counter-width helper used by the top and the response timer.
package usb_txn_pkg;

    // Four-bit packet identifiers driven onto the outbound pipe
    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010
    } pid_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TOKEN,
        S_TOKEN_END,
        S_DATA,
        S_DATA_END,
        S_WAIT_HS,
        S_WAIT_DIN,
        S_SEND_ACK,
        S_ACK_END,
        S_DONE
    } txn_state_t;

    // Bits needed to hold 0..max_val, never less than one bit
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/usb_txn_ctrl_if.sv
// usb_txn_ctrl_if: requester, outbound-pipe and inbound-pipe signals of
// the transaction sequencer, bundled so the sequencer (master) and its
// environment (slave) see the same names.
//
// Handshakes:
//   request : txn_start is a one-cycle pulse honoured only while
//             txn_busy=0; txn_done pulses once per accepted request with
//             txn_ok valid in that cycle.
//   outbound: tx_pktready acts as valid and tx_gotpkt as ready; the packet
//             transfers in the cycle both are 1, and tx_pid/tx_addr/
//             tx_endp/tx_data stay stable while tx_pktready=1. tx_pktend
//             then pulses once the last bit of that packet leaves the wire.
//   inbound : while rx_reading=1 the pipe raises one of rx_pktready/rx_ack/
//             rx_nak/rx_error; rx_got pulses for one cycle when the
//             sequencer consumes that result.
interface usb_txn_ctrl_if;
    logic        txn_start;
    logic        txn_read;
    logic [6:0]  txn_addr;
    logic [3:0]  txn_endp;
    logic [63:0] txn_wdata;
    logic        txn_busy;
    logic        txn_done;
    logic        txn_ok;
    logic [63:0] txn_rdata;

    logic [3:0]  tx_pid;
    logic [3:0]  tx_endp;
    logic [6:0]  tx_addr;
    logic [63:0] tx_data;
    logic        tx_pktready;
    logic        tx_gotpkt;
    logic        tx_pktend;

    logic        rx_reading;
    logic        rx_pktready;
    logic        rx_ack;
    logic        rx_nak;
    logic        rx_error;
    logic [63:0] rx_data;
    logic        rx_got;

    modport master (
        input  txn_start, txn_read, txn_addr, txn_endp, txn_wdata,
        output txn_busy, txn_done, txn_ok, txn_rdata,
        output tx_pid, tx_endp, tx_addr, tx_data, tx_pktready,
        input  tx_gotpkt, tx_pktend,
        output rx_reading, rx_got,
        input  rx_pktready, rx_ack, rx_nak, rx_error, rx_data
    );

    modport slave (
        output txn_start, txn_read, txn_addr, txn_endp, txn_wdata,
        input  txn_busy, txn_done, txn_ok, txn_rdata,
        input  tx_pid, tx_endp, tx_addr, tx_data, tx_pktready,
        output tx_gotpkt, tx_pktend,
        input  rx_reading, rx_got,
        output rx_pktready, rx_ack, rx_nak, rx_error, rx_data
    );
endinterface

// File: rtl/usb_txn_timer.sv
// usb_txn_timer: response-wait timeout counter. Held at zero while clr=1,
// counts while en=1, and flags timeout during the TIMEOUT_CYCLES-th
// enabled cycle so a wait lasts exactly TIMEOUT_CYCLES cycles.
module usb_txn_timer
    import usb_txn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_L,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int CW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear has priority, otherwise advance while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/usb_txn_ctrl.sv
// usb_txn_ctrl: host-side USB transaction sequencer. Issues token, DATA and
// handshake packets for one OUT or IN request at a time, waits for the
// device under a timeout and retries up to MAX_RETRY times.
// Optional feature macro USB_TXN_DATA_TOGGLE_EN: OUT data alternates
// DATA0/DATA1 after each successful OUT; when undefined, always DATA0.
module usb_txn_ctrl
    import usb_txn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRY      = 8
) (
    input  logic                              clk,
    input  logic                              rst_L,
    usb_txn_ctrl_if.master                    bus,
    output txn_state_t                        dbg_state,
    output logic [cnt_width(MAX_RETRY)-1:0]   dbg_retry_cnt
);
    localparam int RW = cnt_width(MAX_RETRY);

    txn_state_t  state_q, state_d;
    logic        read_q, read_d;
    logic [6:0]  addr_q, addr_d;
    logic [3:0]  endp_q, endp_d;
    logic [63:0] wdata_q, wdata_d;
    logic [RW-1:0] retry_q, retry_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic [63:0] rdata_q, rdata_d;
    logic [3:0]  pid_q, pid_d;
    logic [6:0]  tx_addr_q, tx_addr_d;
    logic [3:0]  tx_endp_q, tx_endp_d;
    logic [63:0] tx_data_q, tx_data_d;
    logic        pktready_q, pktready_d;
    logic        reading_q, reading_d;
    logic        got_q, got_d;
    logic        do_retry;
    logic        in_wait;
    logic        timeout;
    logic [3:0]  data_pid;
`ifdef USB_TXN_DATA_TOGGLE_EN
    logic        toggle_q, toggle_d;
`endif

    assign in_wait = (state_q == S_WAIT_HS) || (state_q == S_WAIT_DIN);

    usb_txn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst_L   (rst_L),
        .clr     (!in_wait),
        .en      (in_wait),
        .timeout (timeout)
    );

`ifdef USB_TXN_DATA_TOGGLE_EN
    assign data_pid = toggle_q ? PID_DATA1 : PID_DATA0;
`else
    assign data_pid = PID_DATA0;
`endif

    // Next state, request latch, retry bookkeeping and next registered outputs
    always_comb begin
        state_d   = state_q;
        read_d    = read_q;
        addr_d    = addr_q;
        endp_d    = endp_q;
        wdata_d   = wdata_q;
        retry_d   = retry_q;
        ok_d      = ok_q;
        rdata_d   = rdata_q;
        pid_d     = pid_q;
        tx_addr_d = tx_addr_q;
        tx_endp_d = tx_endp_q;
        tx_data_d = tx_data_q;
        got_d     = 1'b0;
        do_retry  = 1'b0;
`ifdef USB_TXN_DATA_TOGGLE_EN
        toggle_d  = toggle_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.txn_start) begin
                    read_d  = bus.txn_read;
                    addr_d  = bus.txn_addr;
                    endp_d  = bus.txn_endp;
                    wdata_d = bus.txn_wdata;
                    retry_d = '0;
                    ok_d    = 1'b0;
                    state_d = S_TOKEN;
                end
            end
            S_TOKEN:     if (bus.tx_gotpkt) state_d = S_TOKEN_END;
            S_TOKEN_END: if (bus.tx_pktend) state_d = read_q ? S_WAIT_DIN : S_DATA;
            S_DATA:      if (bus.tx_gotpkt) state_d = S_DATA_END;
            S_DATA_END:  if (bus.tx_pktend) state_d = S_WAIT_HS;
            S_WAIT_HS: begin
                // error outranks a coincident ACK; any rx result outranks timeout
                if (bus.rx_error || bus.rx_nak) begin
                    got_d    = 1'b1;
                    do_retry = 1'b1;
                end else if (bus.rx_ack) begin
                    got_d   = 1'b1;
                    ok_d    = 1'b1;
                    state_d = S_DONE;
`ifdef USB_TXN_DATA_TOGGLE_EN
                    toggle_d = ~toggle_q;
`endif
                end else if (timeout) begin
                    do_retry = 1'b1;
                end
            end
            S_WAIT_DIN: begin
                if (bus.rx_error) begin
                    got_d    = 1'b1;
                    do_retry = 1'b1;
                end else if (bus.rx_pktready) begin
                    got_d   = 1'b1;
                    rdata_d = bus.rx_data;
                    state_d = S_SEND_ACK;
                end else if (bus.rx_nak) begin
                    got_d    = 1'b1;
                    do_retry = 1'b1;
                end else if (timeout) begin
                    do_retry = 1'b1;
                end
            end
            S_SEND_ACK: if (bus.tx_gotpkt) state_d = S_ACK_END;
            S_ACK_END: begin
                if (bus.tx_pktend) begin
                    ok_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (do_retry) begin
            if (retry_q == RW'(MAX_RETRY)) begin
                ok_d    = 1'b0;
                state_d = S_DONE;
            end else begin
                retry_d = retry_q + RW'(1);
                state_d = S_TOKEN;
            end
        end

        // Outputs are decoded from the next state so they register in step with it
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        pktready_d = (state_d == S_TOKEN) || (state_d == S_DATA) || (state_d == S_SEND_ACK);
        reading_d  = (state_d == S_WAIT_HS) || (state_d == S_WAIT_DIN);

        // Packet fields load only when a send state is entered, so they hold while offered
        if (state_d != state_q) begin
            if (state_d == S_TOKEN) begin
                pid_d     = read_d ? PID_IN : PID_OUT;
                tx_addr_d = addr_d;
                tx_endp_d = endp_d;
            end else if (state_d == S_DATA) begin
                pid_d     = data_pid;
                tx_data_d = wdata_q;
            end else if (state_d == S_SEND_ACK) begin
                pid_d     = PID_ACK;
            end
        end
    end

    // State, request and output registers; reset aborts any transaction silently
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q    <= S_IDLE;
            read_q     <= 1'b0;
            addr_q     <= '0;
            endp_q     <= '0;
            wdata_q    <= '0;
            retry_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            rdata_q    <= '0;
            pid_q      <= '0;
            tx_addr_q  <= '0;
            tx_endp_q  <= '0;
            tx_data_q  <= '0;
            pktready_q <= 1'b0;
            reading_q  <= 1'b0;
            got_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            endp_q     <= endp_d;
            wdata_q    <= wdata_d;
            retry_q    <= retry_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            rdata_q    <= rdata_d;
            pid_q      <= pid_d;
            tx_addr_q  <= tx_addr_d;
            tx_endp_q  <= tx_endp_d;
            tx_data_q  <= tx_data_d;
            pktready_q <= pktready_d;
            reading_q  <= reading_d;
            got_q      <= got_d;
        end
    end

`ifdef USB_TXN_DATA_TOGGLE_EN
    // Data toggle register, flipped only by a successful OUT
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end
`endif

    assign bus.txn_busy    = busy_q;
    assign bus.txn_done    = done_q;
    assign bus.txn_ok      = ok_q;
    assign bus.txn_rdata   = rdata_q;
    assign bus.tx_pid      = pid_q;
    assign bus.tx_addr     = tx_addr_q;
    assign bus.tx_endp     = tx_endp_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_pktready = pktready_q;
    assign bus.rx_reading  = reading_q;
    assign bus.rx_got      = got_q;
    assign dbg_state       = state_q;
    assign dbg_retry_cnt   = retry_q;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// tb_usb_txn_ctrl: directed bench for usb_txn_ctrl (TIMEOUT_CYCLES=10,
// MAX_RETRY=2). The bench plays both pipes; expected PIDs are queued by
// each scenario and popped as packets are offered.
`timescale 1ns/1ps
module tb_usb_txn_ctrl;
    import usb_txn_pkg::*;

    localparam int TO = 10;
    localparam int MR = 2;

    localparam logic [3:0] P_OUT   = 4'b0001;
    localparam logic [3:0] P_IN    = 4'b1001;
    localparam logic [3:0] P_DATA0 = 4'b0011;
    localparam logic [3:0] P_DATA1 = 4'b1011;
    localparam logic [3:0] P_ACK   = 4'b0010;

    localparam logic [63:0] IN_DATA = 64'h0123456789ABCDEF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_L = 1'b0;
    always #5 clk = ~clk;

    usb_txn_ctrl_if bus();
    txn_state_t dbg_state;
    logic [1:0] dbg_retry_cnt;

    usb_txn_ctrl #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
        .clk           (clk),
        .rst_L         (rst_L),
        .bus           (bus),
        .dbg_state     (dbg_state),
        .dbg_retry_cnt (dbg_retry_cnt)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];
    logic exp_toggle = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] data_pid();
`ifdef USB_TXN_DATA_TOGGLE_EN
        return exp_toggle ? P_DATA1 : P_DATA0;
`else
        return P_DATA0;
`endif
    endfunction

    // ---------------- driver tasks (all start and end at a negedge) ----------------
    task automatic drive_idle();
        bus.txn_start   = 1'b0;
        bus.txn_read    = 1'b0;
        bus.txn_addr    = '0;
        bus.txn_endp    = '0;
        bus.txn_wdata   = '0;
        bus.tx_gotpkt   = 1'b0;
        bus.tx_pktend   = 1'b0;
        bus.rx_pktready = 1'b0;
        bus.rx_ack      = 1'b0;
        bus.rx_nak      = 1'b0;
        bus.rx_error    = 1'b0;
        bus.rx_data     = '0;
    endtask

    task automatic start_txn(input string tag, input logic rd, input logic [6:0] a,
                             input logic [3:0] e, input logic [63:0] wd);
        bus.txn_read  = rd;
        bus.txn_addr  = a;
        bus.txn_endp  = e;
        bus.txn_wdata = wd;
        bus.txn_start = 1'b1;
        @(negedge clk);
        bus.txn_start = 1'b0;
        check({tag, "_busy"}, 64'(bus.txn_busy), 64'd1);
    endtask

    // Accept one outbound packet (after a one-cycle stall) and end it
    task automatic handle_pkt(input string tag, input logic chk_hdr, input logic [6:0] a,
                              input logic [3:0] e, input logic chk_data, input logic [63:0] d);
        int i;
        logic [3:0] exp_pid;
        i = 0;
        while (!bus.tx_pktready && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (!bus.tx_pktready) begin
            check({tag, "_pktready_wait"}, 64'd0, 64'd1);
            return;
        end
        exp_pid = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
        check({tag, "_pid"}, 64'(bus.tx_pid), 64'(exp_pid));
        if (chk_hdr) begin
            check({tag, "_addr"}, 64'(bus.tx_addr), 64'(a));
            check({tag, "_endp"}, 64'(bus.tx_endp), 64'(e));
        end
        if (chk_data) check({tag, "_data"}, bus.tx_data, d);
        @(negedge clk);
        check({tag, "_pid_hold"}, 64'(bus.tx_pid), 64'(exp_pid));
        bus.tx_gotpkt = 1'b1;
        @(negedge clk);
        bus.tx_gotpkt = 1'b0;
        check({tag, "_pktready_drop"}, 64'(bus.tx_pktready), 64'd0);
        bus.tx_pktend = 1'b1;
        @(negedge clk);
        bus.tx_pktend = 1'b0;
    endtask

    task automatic wait_reading(input string tag);
        int i;
        i = 0;
        while (!bus.rx_reading && i < 50) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_reading"}, 64'(bus.rx_reading), 64'd1);
    endtask

    // kind: 0=ack 1=nak 2=error 3=pktready with data
    task automatic rx_pulse(input string tag, input int kind, input logic [63:0] d);
        case (kind)
            0: bus.rx_ack = 1'b1;
            1: bus.rx_nak = 1'b1;
            2: bus.rx_error = 1'b1;
            default: begin
                bus.rx_pktready = 1'b1;
                bus.rx_data = d;
            end
        endcase
        @(negedge clk);
        bus.rx_ack = 1'b0;
        bus.rx_nak = 1'b0;
        bus.rx_error = 1'b0;
        bus.rx_pktready = 1'b0;
        check({tag, "_rx_got"}, 64'(bus.rx_got), 64'd1);
    endtask

    task automatic wait_done(input string tag, input logic exp_ok);
        int i;
        i = 0;
        while (!bus.txn_done && i < 60) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_done"}, 64'(bus.txn_done), 64'd1);
        check({tag, "_ok"}, 64'(bus.txn_ok), 64'(exp_ok));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(bus.txn_done), 64'd0);
    endtask

    // Full OUT transaction: n_nak NAKs then an ACK
    task automatic run_out(input string tag, input logic [6:0] a, input logic [3:0] e,
                           input logic [63:0] wd, input int n_nak, input logic stray);
        start_txn(tag, 1'b0, a, e, wd);
        for (int k = 0; k <= n_nak; k++) begin
            exp_q.push_back(P_OUT);
            exp_q.push_back(data_pid());
            handle_pkt({tag, "_tok"}, 1'b1, a, e, 1'b0, 64'd0);
            handle_pkt({tag, "_dat"}, 1'b0, 7'd0, 4'd0, 1'b1, wd);
            wait_reading(tag);
            check({tag, "_st_wait_hs"}, 64'(dbg_state), 64'(S_WAIT_HS));
            check({tag, "_retry"}, 64'(dbg_retry_cnt), 64'(k));
            if (stray && k == 0) begin
                bus.tx_pktend = 1'b1;
                bus.txn_start = 1'b1;
                @(negedge clk);
                bus.tx_pktend = 1'b0;
                bus.txn_start = 1'b0;
                check({tag, "_stray_ignored"}, 64'(dbg_state), 64'(S_WAIT_HS));
            end
            rx_pulse(tag, (k < n_nak) ? 1 : 0, 64'd0);
        end
        exp_toggle = ~exp_toggle;
        wait_done(tag, 1'b1);
        check({tag, "_retry_end"}, 64'(dbg_retry_cnt), 64'(n_nak));
        if (stray) begin
            check({tag, "_idle0"}, 64'(bus.txn_busy), 64'd0);
            @(negedge clk);
            check({tag, "_idle1"}, 64'(bus.txn_busy), 64'd0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n_wait;
        int n_done;
        drive_idle();
        rst_L = 1'b0;
        repeat (3) @(negedge clk);
        rst_L = 1'b1;

        // reset state
        check("rst_busy", 64'(bus.txn_busy), 64'd0);
        check("rst_done", 64'(bus.txn_done), 64'd0);
        check("rst_ok", 64'(bus.txn_ok), 64'd0);
        check("rst_rdata", bus.txn_rdata, 64'd0);
        check("rst_pktready", 64'(bus.tx_pktready), 64'd0);
        check("rst_pid", 64'(bus.tx_pid), 64'd0);
        check("rst_reading", 64'(bus.rx_reading), 64'd0);
        check("rst_got", 64'(bus.rx_got), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        check("rst_retry", 64'(dbg_retry_cnt), 64'd0);

        // 1: plain OUT, with a stray tx_pktend and a busy txn_start during the wait
        run_out("out1", 7'd5, 4'd1, 64'hDEADBEEF_CAFEF00D, 0, 1'b1);

        // 2: IN with data returned, ACK sent back
        start_txn("in1", 1'b1, 7'd3, 4'd2, 64'd0);
        exp_q.push_back(P_IN);
        handle_pkt("in1_tok", 1'b1, 7'd3, 4'd2, 1'b0, 64'd0);
        wait_reading("in1");
        check("in1_st_wait_din", 64'(dbg_state), 64'(S_WAIT_DIN));
        rx_pulse("in1", 3, IN_DATA);
        exp_q.push_back(P_ACK);
        handle_pkt("in1_ack", 1'b0, 7'd0, 4'd0, 1'b0, 64'd0);
        wait_done("in1", 1'b1);
        check("in1_rdata", bus.txn_rdata, IN_DATA);

        // 3: OUT NAKed twice, then ACKed
        run_out("out_nak", 7'd9, 4'd4, 64'h1111_2222_3333_4444, 2, 1'b0);

        // 4: IN with no response: three tokens, ten-cycle waits, then failure
        start_txn("in_to", 1'b1, 7'd3, 4'd2, 64'd0);
        for (int k = 0; k <= MR; k++) begin
            exp_q.push_back(P_IN);
            handle_pkt("in_to_tok", 1'b1, 7'd3, 4'd2, 1'b0, 64'd0);
            wait_reading("in_to");
            n_wait = 0;
            while (bus.rx_reading && n_wait < 50) begin
                @(negedge clk);
                n_wait++;
            end
            check("in_to_wait_len", 64'(n_wait), 64'(TO));
        end
        wait_done("in_to", 1'b0);
        check("in_to_rdata_kept", bus.txn_rdata, IN_DATA);
        check("in_to_retry", 64'(dbg_retry_cnt), 64'(MR));
        check("in_to_no_ack", 64'(bus.tx_pktready), 64'd0);

        // 5: two back-to-back successful OUTs (DATA0/DATA1 alternate only with toggling)
        run_out("out_a", 7'd1, 4'd0, 64'hAAAA_0000_AAAA_0000, 0, 1'b0);
        run_out("out_b", 7'd1, 4'd0, 64'h5555_FFFF_5555_FFFF, 0, 1'b0);

        // 6: reset during WAIT_HS aborts with no txn_done
        start_txn("rst_mid", 1'b0, 7'd6, 4'd3, 64'hFEED_0000_0000_BEEF);
        exp_q.push_back(P_OUT);
        exp_q.push_back(data_pid());
        handle_pkt("rst_mid_tok", 1'b1, 7'd6, 4'd3, 1'b0, 64'd0);
        handle_pkt("rst_mid_dat", 1'b0, 7'd0, 4'd0, 1'b1, 64'hFEED_0000_0000_BEEF);
        wait_reading("rst_mid");
        #2;
        rst_L = 1'b0;
        #1;
        check("rst_mid_busy", 64'(bus.txn_busy), 64'd0);
        check("rst_mid_reading", 64'(bus.rx_reading), 64'd0);
        check("rst_mid_rdata", bus.txn_rdata, 64'd0);
        check("rst_mid_state", 64'(dbg_state), 64'(S_IDLE));
        exp_toggle = 1'b0;
        @(negedge clk);
        rst_L = 1'b1;
        n_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.txn_done) n_done++;
        end
        check("rst_mid_no_done", 64'(n_done), 64'd0);
        run_out("after_rst", 7'd2, 4'd7, 64'h0F0F_0F0F_0F0F_0F0F, 0, 1'b0);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
